// File: rtl/stream_tx_if.sv
// FX3 slave-FIFO write-side bus plus the local show-ahead FIFO read port.
interface stream_tx_if;
  logic        FLAGA;
  logic        rdempty;
  logic [31:0] q;
  logic        rdreq;
  logic        SLCS;
  logic        SLWR;
  logic        SLOE;
  logic        SLRD;
  logic        PKTEND;
  logic        A1;
  logic        A0;
  logic [31:0] DQ_out;
  logic        DQ_oe;

  modport master (
    input  FLAGA, rdempty, q,
    output rdreq, SLCS, SLWR, SLOE, SLRD, PKTEND, A1, A0, DQ_out, DQ_oe
  );

  modport slave (
    output FLAGA, rdempty, q,
    input  rdreq, SLCS, SLWR, SLOE, SLRD, PKTEND, A1, A0, DQ_out, DQ_oe
  );
endinterface

// File: rtl/stream_tx.sv
// Streams local FIFO words into the FX3 write socket in BURST_LEN-word bursts; strobes registered, rdreq combinational.
// Optional short-packet commit after PKT_TIMEOUT starved cycles: define STREAM_TX_PKTEND_EN.
module stream_tx #(
  parameter int BURST_LEN   = 1024,
  parameter int PKT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DATA_DIR,
  stream_tx_if.master bus,
  output logic [15:0] usb_wr_cnt,
  output logic [2:0]  usb_wr_state,
  output logic        burst_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SELECT = 3'd2,
    S_BURST  = 3'd3,
    S_SHORT  = 3'd4,
    S_END    = 3'd5
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] setup_cnt;
  logic       room;
  logic       wr_en;
  logic       starved;

  assign room      = (usb_wr_cnt < 16'(BURST_LEN));
  assign wr_en     = !rst && DATA_DIR && (state == S_BURST) && bus.FLAGA && !bus.rdempty && room;
  assign bus.rdreq = wr_en;
  assign usb_wr_state = state;

`ifdef STREAM_TX_PKTEND_EN
  logic [15:0] empty_cnt;

  assign starved = (state == S_BURST) && (usb_wr_cnt != 16'd0) && bus.rdempty &&
                   (empty_cnt == 16'(PKT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != S_BURST || usb_wr_cnt == 16'd0 || !bus.rdempty) begin
      empty_cnt <= 16'd0;
    end else if (!starved) begin
      empty_cnt <= empty_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign starved        = 1'b0;
  assign unused_timeout = (PKT_TIMEOUT > 0);
`endif

  always_comb begin
    nxt = state;
    // Losing write ownership aborts from anywhere, ahead of any other transition.
    if (state != S_IDLE && !DATA_DIR) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (DATA_DIR) nxt = S_SETUP;
        S_SETUP:  if (setup_cnt == 2'd3) nxt = S_SELECT;
        S_SELECT: nxt = S_BURST;
        S_BURST: begin
          if (!room)        nxt = S_END;
          else if (starved) nxt = S_SHORT;
        end
        S_SHORT:  nxt = S_END;
        S_END:    nxt = S_SETUP;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      setup_cnt  <= 2'd0;
      bus.SLCS   <= 1'b1;
      bus.SLWR   <= 1'b1;
      bus.SLOE   <= 1'b1;
      bus.SLRD   <= 1'b1;
      bus.PKTEND <= 1'b1;
      bus.A1     <= 1'b0;
      bus.A0     <= 1'b0;
      bus.DQ_out <= 32'd0;
      bus.DQ_oe  <= 1'b0;
      usb_wr_cnt <= 16'd0;
      burst_done <= 1'b0;
    end else begin
      state      <= nxt;
      setup_cnt  <= (state == S_SETUP) ? setup_cnt + 2'd1 : 2'd0;
      bus.SLCS   <= !(nxt inside {S_SELECT, S_BURST, S_SHORT, S_END});
      bus.DQ_oe  <= (nxt inside {S_SELECT, S_BURST, S_SHORT, S_END});
      bus.SLWR   <= !wr_en;
      bus.SLOE   <= 1'b1;
      bus.SLRD   <= 1'b1;
      bus.PKTEND <= (nxt != S_SHORT);
      bus.A1     <= 1'b0;
      bus.A0     <= 1'b0;
      burst_done <= (nxt == S_END);
      // The popped word lands on the bus with its SLWR strobe one cycle later.
      if (wr_en) begin
        bus.DQ_out <= bus.q;
        usb_wr_cnt <= usb_wr_cnt + 16'd1;
      end else if (nxt == S_SETUP) begin
        usb_wr_cnt <= 16'd0;
      end
    end
  end

endmodule

// File: doc/stream_tx.md
STREAM_TX -- requirements
Module: stream_tx

Interface
REQ-001 SHALL have parameter BURST_LEN, default 1024: words written per burst, legal range 1..65535.
REQ-002 SHALL have parameter PKT_TIMEOUT, default 64: empty-FIFO cycles before a short-packet commit.
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: DATA_DIR  in  1  1 = write direction owned by this block; FLAGA  in  1  FX3 write buffer ready, active high.
REQ-005 SHALL have ports: rdempty  in  1  local FIFO empty; q  in  32  local FIFO head word (show-ahead); rdreq  out  1  FIFO pop.
REQ-006 SHALL have ports: SLCS, SLWR, SLOE, SLRD, PKTEND  out  1 each  FX3 strobes, active low; A1, A0  out  1 each  socket address.
REQ-007 SHALL have ports: DQ_out  out  32  bus data; DQ_oe  out  1  bus drive enable.
REQ-008 SHALL have ports: usb_wr_cnt  out  16  words in current burst; usb_wr_state  out  3  state code; burst_done  out  1  one-cycle pulse.

Function
REQ-009 States SHALL be IDLE=0, SETUP=1, SELECT=2, BURST=3, SHORT=4, END=5; all outputs except rdreq SHALL be registered.
REQ-010 IDLE: outputs inactive; DATA_DIR=1 sampled -> SETUP next cycle.
REQ-011 SETUP SHALL last exactly 4 cycles with A1=A0=0, SLCS=1, DQ_oe=0, usb_wr_cnt cleared; then SELECT.
REQ-012 SELECT SHALL last 1 cycle with SLCS=0, DQ_oe=1; then BURST.
REQ-013 BURST: SLCS=0, DQ_oe=1; rdreq SHALL equal (state==BURST && FLAGA && !rdempty && usb_wr_cnt<BURST_LEN), combinational.
REQ-014 On each rdreq cycle, next cycle SHALL show SLWR=0, DQ_out=q, and usb_wr_cnt incremented by 1; otherwise SLWR=1, DQ_out holds.
REQ-015 FLAGA=0 or rdempty=1 in BURST SHALL stall with no write and no pop; no word lost or duplicated.
REQ-016 usb_wr_cnt==BURST_LEN in BURST -> END; END lasts 1 cycle, SLCS=0, SLWR=1, burst_done=1; then SETUP if DATA_DIR=1 else IDLE.
REQ-017 SLOE and SLRD SHALL remain 1 in every state; PKTEND SHALL be 1 except as in REQ-024.
REQ-018 DATA_DIR=0 in any non-IDLE state SHALL abort: rdreq=0 that cycle, IDLE next cycle, DQ_oe=0, burst_done not pulsed.
REQ-019 usb_wr_cnt SHALL never exceed BURST_LEN; no wrap.
REQ-020 usb_wr_state SHALL equal the current state code.

Reset
REQ-021 rst=1 at any clk edge SHALL force IDLE, SLCS=SLWR=SLOE=SLRD=PKTEND=1, A1=A0=0, DQ_out=0, DQ_oe=0, usb_wr_cnt=0, burst_done=0.
REQ-022 rdreq SHALL be 0 while rst=1, including mid-burst; burst restarts from SETUP after release.

Configuration
REQ-023 Macro STREAM_TX_PKTEND_EN SHALL enable short-packet commit.
REQ-024 Defined: in BURST with usb_wr_cnt>0 and rdempty=1 for PKT_TIMEOUT consecutive cycles -> SHORT: 1 cycle, SLCS=0, PKTEND=0, SLWR=1; then END (burst_done=1).
REQ-025 Not defined: no empty timer, SHORT unreachable, PKTEND constant 1, BURST waits indefinitely on rdempty.

Verification
REQ-026 rst 2 cycles, DATA_DIR=1, FLAGA=1, FIFO full, BURST_LEN=4 -> SLWR low 4 consecutive cycles starting 6 cycles after DATA_DIR, DQ_out=q sequence, burst_done pulse, SETUP re-entered.
REQ-027 BURST_LEN=8, FLAGA=0 for 3 cycles after word 3 -> exactly 8 pops, 8 SLWR pulses, no gap data repeated.
REQ-028 DATA_DIR 1->0 after 5 of 1024 words -> IDLE next cycle, DQ_oe=0, usb_wr_cnt frozen then cleared on next SETUP, no burst_done.
REQ-029 rst=1 mid-burst at word 100 -> all outputs at REQ-021 values next cycle, rdreq=0.
REQ-030 STREAM_TX_PKTEND_EN, PKT_TIMEOUT=4, 3 words then rdempty=1 -> PKTEND low 1 cycle after 4 empty cycles, then burst_done; without macro -> PKTEND stays 1, state stays BURST.
